// File: rtl/tile_pkg.sv
// Shared encodings for the tile sequencer: FSM states, ROM read phases, rest-lane rule, lane decode.
// Latency: none, types and pure functions only.
// Backpressure: none.
package tile_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_CURR,
        ST_FETCH_NEXT,
        ST_PLAY,
        ST_DONE
    } state_t;

    // ROM access is strobe-then-data: ISSUE drives rom_rd, WAIT is the cycle the data is valid.
    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_WAIT
    } rd_phase_t;

    localparam int MAX_LANES = 64;

    // A lane index equal to the lane count encodes a rest; anything above is treated the same way.
    function automatic logic is_rest(input int unsigned lane_idx, input int unsigned lanes);
        return lane_idx >= lanes;
    endfunction

    function automatic logic [MAX_LANES-1:0] lane_onehot(input int unsigned lane_idx,
                                                         input int unsigned lanes);
        logic [MAX_LANES-1:0] oh;
        oh = '0;
        if (!is_rest(lane_idx, lanes))
            oh = MAX_LANES'(1) << lane_idx;
        return oh;
    endfunction

endpackage

// File: rtl/tile_sequencer_if.sv
// Song ROM port: read strobe plus address out, lane/hold back one cycle later.
// Latency: data valid the cycle after rom_rd.
// Backpressure: none, the ROM always answers.
interface tile_sequencer_if #(
    parameter int LANES    = 12,
    parameter int SONG_LEN = 12,
    parameter int HOLD_W   = 4
);
    localparam int AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int LW = $clog2(LANES + 1);

    logic              rom_rd;
    logic [AW-1:0]     rom_addr;
    logic [LW-1:0]     rom_lane;
    logic [HOLD_W-1:0] rom_hold;

    modport master (output rom_rd, output rom_addr, input rom_lane, input rom_hold);
    modport slave  (input rom_rd, input rom_addr, output rom_lane, output rom_hold);
endinterface

// File: rtl/beat_divider.sv
// Beat divider: counts 0..BEAT_CYCLES-1, one-cycle tick on the terminal count, beat high in first half.
// Latency: tick is combinational from the count register.
// Backpressure: en low freezes the count; active low clears it so every play starts a fresh beat.
module beat_divider #(
    parameter int BEAT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic en,
    output logic tick,
    output logic beat
);
    localparam int CW = $clog2(BEAT_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(BEAT_CYCLES - 1);
    localparam logic [CW-1:0] HALF = CW'(BEAT_CYCLES / 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (!active)
            count <= '0;
        else if (en)
            count <= (count == TERM) ? '0 : count + 1'b1;
    end

    assign tick = active && en && (count == TERM);
    assign beat = active && (count < HALF);
endmodule

// File: rtl/tile_sequencer.sv
// Song sequencer: beats from CLOCK_50, walks the song ROM, shows current/next lanes, scores keys (TILE_LOOP_EN: loop song forever).
// Latency: start to PLAY in 4 cycles; scoring and note advance on the beat's terminal cycle.
// Backpressure: pause freezes divider, FSM, prefetch and score; start ignored while paused or playing.
module tile_sequencer
    import tile_pkg::*;
#(
    parameter int LANES       = 12,
    parameter int SONG_LEN    = 12,
    parameter int BEAT_CYCLES = 50000000,
    parameter int HOLD_W      = 4,
    parameter int SCORE_W     = 17,
    parameter int SCORE_MAX   = 9990,
    parameter int POINTS      = 10,
    localparam int AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1,
    localparam int LW = $clog2(LANES + 1)
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               start,
    input  logic               pause,
    input  logic [LANES-1:0]   keys,
    tile_sequencer_if.master   rom,
    output logic [LANES-1:0]   curr_note,
    output logic [LANES-1:0]   next_note,
    output logic [HOLD_W-1:0]  hold_left,
    output logic [AW-1:0]      game_frame,
    output logic               beat,
    output logic [SCORE_W-1:0] score,
    output logic               hit,
    output logic               miss,
    output logic               playing,
    output logic               done
);
    localparam logic [LW-1:0]      REST_LANE  = LW'(LANES);
    localparam logic [AW-1:0]      LAST_FRAME = AW'(SONG_LEN - 1);
    localparam logic [SCORE_W:0]   SAT        = (SCORE_W + 1)'(SCORE_MAX);
    localparam logic [SCORE_W:0]   PTS        = (SCORE_W + 1)'(POINTS);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

    state_t            state, state_d;
    rd_phase_t         phase, phase_d;
    logic [LW-1:0]     curr_lane, next_lane;
    logic [HOLD_W-1:0] next_hold;
    logic              in_play, beat_tick, curr_rest, advance, song_end;
    logic [AW-1:0]     frame_inc;
    logic [SCORE_W:0]  score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic [HOLD_W-1:0] rom_hold_min1, next_hold_min1;

    assign in_play   = (state == ST_PLAY);
    assign curr_rest = is_rest(32'(curr_lane), LANES);
    assign advance   = beat_tick && (hold_left <= HOLD_ONE);
    assign frame_inc = (game_frame == LAST_FRAME) ? '0 : game_frame + 1'b1;
`ifdef TILE_LOOP_EN
    assign song_end  = 1'b0;
`else
    assign song_end  = advance && (game_frame == LAST_FRAME);
`endif

    assign score_sum      = {1'b0, score} + PTS;
    assign score_sat      = (score_sum > SAT) ? SAT[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
    assign rom_hold_min1  = (rom.rom_hold == '0) ? HOLD_ONE : rom.rom_hold;
    assign next_hold_min1 = (next_hold == '0) ? HOLD_ONE : next_hold;

    beat_divider #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat_divider (
        .clk    (CLOCK_50),
        .rst_n  (reset_n),
        .active (in_play),
        .en     (in_play && !pause),
        .tick   (beat_tick),
        .beat   (beat)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            phase <= RD_IDLE;
        end else begin
            state <= state_d;
            phase <= phase_d;
        end
    end

    always_comb begin
        state_d = state;
        phase_d = phase;
        if (!pause) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_FETCH_CURR;
                        phase_d = RD_ISSUE;
                    end
                end
                ST_FETCH_CURR: begin
                    if (phase == RD_WAIT) begin
                        state_d = ST_FETCH_NEXT;
                        phase_d = RD_ISSUE;
                    end else begin
                        phase_d = RD_WAIT;
                    end
                end
                ST_FETCH_NEXT: begin
                    if (phase == RD_WAIT) begin
                        state_d = ST_PLAY;
                        phase_d = RD_IDLE;
                    end else begin
                        phase_d = RD_WAIT;
                    end
                end
                ST_PLAY: begin
                    if (song_end) begin
                        state_d = ST_DONE;
                        phase_d = RD_IDLE;
                    end else if (advance) begin
                        phase_d = RD_ISSUE;
                    end else if (phase == RD_ISSUE) begin
                        phase_d = RD_WAIT;
                    end else begin
                        phase_d = RD_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = RD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            curr_lane  <= REST_LANE;
            next_lane  <= REST_LANE;
            next_hold  <= '0;
            hold_left  <= '0;
            game_frame <= '0;
            score      <= '0;
        end else if (!pause) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        game_frame <= '0;
                        score      <= '0;
                    end
                end
                ST_FETCH_CURR: begin
                    if (phase == RD_WAIT) begin
                        curr_lane <= rom.rom_lane;
                        hold_left <= rom_hold_min1;
                    end
                end
                ST_FETCH_NEXT: begin
                    if (phase == RD_WAIT) begin
                        next_lane <= rom.rom_lane;
                        next_hold <= rom.rom_hold;
                    end
                end
                ST_PLAY: begin
                    if (beat_tick && !curr_rest && (keys == curr_note))
                        score <= score_sat;
                    if (song_end) begin
                        curr_lane <= REST_LANE;
                        next_lane <= REST_LANE;
                        hold_left <= '0;
                    end else if (advance) begin
                        curr_lane  <= next_lane;
                        hold_left  <= next_hold_min1;
                        game_frame <= frame_inc;
                    end else begin
                        if (beat_tick)
                            hold_left <= hold_left - 1'b1;
                        if (phase == RD_WAIT) begin
                            next_lane <= rom.rom_lane;
                            next_hold <= rom.rom_hold;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Prefetch always targets the entry after the current frame, so it also serves the initial next fetch.
    assign rom.rom_rd   = !pause && (phase == RD_ISSUE);
    assign rom.rom_addr = !rom.rom_rd ? '0 : (state == ST_FETCH_CURR) ? '0 : frame_inc;

    assign curr_note = LANES'(lane_onehot(32'(curr_lane), LANES));
    assign next_note = LANES'(lane_onehot(32'(next_lane), LANES));
    assign hit       = beat_tick && !curr_rest && (keys == curr_note);
    assign miss      = beat_tick && !curr_rest && (keys != curr_note);
    assign playing   = in_play;
    assign done      = (state == ST_DONE);
endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer: 4 lanes, 3-entry song, 4-cycle beat, plus a low-ceiling score instance.
// Latency: expectations assume start-to-PLAY of 4 cycles and a tick on the 4th cycle of each beat.
// Backpressure: pause is exercised mid-beat.
module tb_tile_sequencer;
    localparam int LANES = 4;
    localparam int SONG_LEN = 3;
    localparam int BEAT = 4;
    localparam int HOLD_W = 4;
    localparam int SCORE_W = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, pause;
    logic [3:0] keys;

    logic [3:0]  curr_note, next_note, hold_left, s_curr, s_next, s_hold;
    logic [1:0]  game_frame, s_frame;
    logic [16:0] score, s_score;
    logic        beat, hit, miss, playing, done;
    logic        s_beat, s_hit, s_miss, s_playing, s_done;

    tile_sequencer_if #(.LANES(LANES), .SONG_LEN(SONG_LEN), .HOLD_W(HOLD_W)) rom_if ();
    tile_sequencer_if #(.LANES(LANES), .SONG_LEN(SONG_LEN), .HOLD_W(HOLD_W)) sat_if ();

    tile_sequencer #(.LANES(LANES), .SONG_LEN(SONG_LEN), .BEAT_CYCLES(BEAT), .HOLD_W(HOLD_W),
                     .SCORE_W(SCORE_W), .SCORE_MAX(9990), .POINTS(10)) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .start(start), .pause(pause), .keys(keys), .rom(rom_if.master),
        .curr_note(curr_note), .next_note(next_note), .hold_left(hold_left), .game_frame(game_frame),
        .beat(beat), .score(score), .hit(hit), .miss(miss), .playing(playing), .done(done));

    tile_sequencer #(.LANES(LANES), .SONG_LEN(SONG_LEN), .BEAT_CYCLES(BEAT), .HOLD_W(HOLD_W),
                     .SCORE_W(SCORE_W), .SCORE_MAX(25), .POINTS(10)) dut_sat (
        .CLOCK_50(clk), .reset_n(rst_n), .start(start), .pause(pause), .keys(keys), .rom(sat_if.master),
        .curr_note(s_curr), .next_note(s_next), .hold_left(s_hold), .game_frame(s_frame),
        .beat(s_beat), .score(s_score), .hit(s_hit), .miss(s_miss), .playing(s_playing), .done(s_done));

    // Song: (lane1,hold1), (lane2,hold2), (rest,hold0)
    function automatic logic [2:0] lane_of(input logic [1:0] a);
        case (a)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] hold_of(input logic [1:0] a);
        case (a)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rom_if.rom_rd) begin
            rom_if.rom_lane <= lane_of(rom_if.rom_addr);
            rom_if.rom_hold <= hold_of(rom_if.rom_addr);
        end
    end

    always @(posedge clk) begin
        if (sat_if.rom_rd) begin
            sat_if.rom_lane <= lane_of(sat_if.rom_addr);
            sat_if.rom_hold <= hold_of(sat_if.rom_addr);
        end
    end

    // One beat per song position in steady play: keys that hit, expected hit, next_note seen at the tick.
    logic [3:0] pat_keys [0:3] = '{4'b0010, 4'b0100, 4'b0100, 4'b0000};
    logic [3:0] pat_next [0:3] = '{4'b0100, 4'b0000, 4'b0000, 4'b0010};
    logic       pat_hit  [0:3] = '{1'b1, 1'b1, 1'b1, 1'b0};

    int errors = 0;
    int checks = 0;
    int hits = 0;
    int pos = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered #1 after the edge that starts a beat; leaves #1 after that beat's tick edge.
    task automatic play_beat(input logic [3:0] k, input logic exp_hit, input logic exp_miss,
                             input logic [3:0] exp_next);
        keys = k;
        chk("beat_first_half", beat, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hit_pulse", hit, exp_hit);
        chk("miss_pulse", miss, exp_miss);
        chk("next_note_at_tick", next_note, exp_next);
        chk("beat_second_half", beat, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_and_wait();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("latency_not_yet", playing, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        pause = 1'b0;
        keys  = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {curr_note, next_note, hold_left, game_frame, beat, hit, miss, playing,
                              done, rom_if.rom_rd, rom_if.rom_addr}, 0);
        chk("reset_score", score, 0);
        start = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First game: hit, miss with a pause inside, hit, rest.
        pulse_start_and_wait();
        chk("play_state", {playing, done}, 2'b10);
        chk("first_curr", curr_note, 4'b0010);
        chk("first_next", next_note, 4'b0100);
        chk("first_hold_frame", {hold_left, game_frame}, {4'd1, 2'd0});

        play_beat(4'b0010, 1'b1, 1'b0, 4'b0100);
        chk("beat1_score", score, 10);
        chk("beat1_advance", {curr_note, hold_left, game_frame}, {4'b0100, 4'd2, 2'd1});

        keys = 4'b0000;
        @(posedge clk);
        #1;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("pause_no_pulse", {hit, miss}, 2'b00);
            chk("pause_frozen", {game_frame, hold_left, beat}, {2'd1, 4'd2, 1'b1});
        end
        @(posedge clk);
        #1;
        pause = 1'b0;
        @(posedge clk);
        #1;
        chk("resume_count2", {beat, hit, miss}, 3'b000);
        @(posedge clk);
        @(negedge clk);
        chk("resume_miss", {hit, miss}, 2'b01);
        @(posedge clk);
        #1;
        chk("beat2_hold_dec", {curr_note, hold_left, game_frame}, {4'b0100, 4'd1, 2'd1});
        chk("beat2_score", score, 10);

        play_beat(4'b0100, 1'b1, 1'b0, 4'b0000);
        chk("beat3_score", score, 20);
        chk("beat3_rest", {curr_note, hold_left, game_frame}, {4'b0000, 4'd1, 2'd2});
        hits = 2;

        play_beat(4'b0000, 1'b0, 1'b0, 4'b0010);
`ifndef TILE_LOOP_EN
        chk("end_status", {playing, done, beat}, 3'b010);
        chk("end_clear", {curr_note, next_note, hold_left}, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("end_score_held", score, 20);
        chk("end_still_done", done, 1);

        pulse_start_and_wait();
        chk("restart_frame_score", {game_frame, score}, 0);
        chk("restart_curr", curr_note, 4'b0010);
        for (int b = 0; b < 4; b++)
            play_beat(pat_keys[b], pat_hit[b], 1'b0, pat_next[b]);
        chk("all_hit_score", score, 30);
        chk("saturated_score", s_score, 25);
        chk("all_hit_done", done, 1);

        pulse_start_and_wait();
        play_beat(4'b0010, 1'b1, 1'b0, 4'b0100);
`else
        chk("loop_wrap", {game_frame, curr_note, hold_left}, {2'd0, 4'b0010, 4'd1});
        chk("loop_status", {playing, done}, 2'b10);
        start = 1'b1;
        play_beat(4'b0010, 1'b1, 1'b0, 4'b0100);
        start = 1'b0;
        hits++;
        chk("start_ignored", {playing, game_frame}, {1'b1, 2'd1});
        chk("loop_score", score, 30);
        pos = 1;
        while (hits < 999) begin
            play_beat(pat_keys[pos], pat_hit[pos], 1'b0, pat_next[pos]);
            if (pat_hit[pos])
                hits++;
            pos = (pos + 1) % 4;
        end
        chk("sat_reach", score, 9990);
        chk("sat_low_ceiling", s_score, 25);
        while (!pat_hit[pos]) begin
            play_beat(pat_keys[pos], pat_hit[pos], 1'b0, pat_next[pos]);
            pos = (pos + 1) % 4;
        end
        play_beat(pat_keys[pos], pat_hit[pos], 1'b0, pat_next[pos]);
        pos = (pos + 1) % 4;
        chk("sat_hold", score, 9990);
        if (pos == 2) begin
            play_beat(pat_keys[pos], pat_hit[pos], 1'b0, pat_next[pos]);
            pos = 3;
        end
`endif
        // Just past an advancing tick: prefetch is in flight.
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {curr_note, next_note, hold_left, game_frame, beat, hit, miss,
                                    playing, done, rom_if.rom_rd}, 0);
        chk("async_reset_score", {score, s_score}, 0);
        keys = 4'b0000;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start_and_wait();
        chk("post_reset_notes", {curr_note, next_note}, {4'b0010, 4'b0100});
        chk("post_reset_state", {hold_left, game_frame, playing}, {4'd1, 2'd0, 1'b1});
        chk("post_reset_score", score, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Parametrised successor to the fixed-length game engine: turns CLOCK_50 into beats, walks a song stored in an external ROM, presents current/next note as one-hot lanes with hold countdown, and scores keypresses.
- Sits between the keypad reader and the LED/GPIO/hex display logic. Replaces the hard-wired period generator, 8-bit frame counter and engine.

Parameters:
- LANES, 12, number of note lanes. One-hot output width.
- SONG_LEN, 12, song entries. The frame counter wraps or ends at SONG_LEN-1.
- BEAT_CYCLES, 50000000, CLOCK_50 cycles per beat. Must be at least 4.
- HOLD_W, 4, width of the hold-length field.
- SCORE_W, 17, score width.
- SCORE_MAX, 9990, score saturation value.
- POINTS, 10, score added per hit.

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins play from frame 0 when in IDLE or DONE
- pause  in  1  level; freezes beat divider and all game state
- keys  in  LANES  one-hot pressed lanes, already synchronous to CLOCK_50
- rom_rd  out  1  ROM read strobe
- rom_addr  out  clog2(SONG_LEN)  ROM address
- rom_lane  in  clog2(LANES+1)  lane index; the value LANES means rest. Valid 1 cycle after rom_rd.
- rom_hold  in  HOLD_W  beats to hold; 0 is treated as 1
- curr_note  out  LANES  one-hot current note; 0 for rest
- next_note  out  LANES  one-hot next note
- hold_left  out  HOLD_W  beats remaining on current note
- game_frame  out  clog2(SONG_LEN)  index of current note
- beat  out  1  metronome level: high for the first half of each beat while PLAY
- score  out  SCORE_W  saturating score
- hit, miss  out  1  single-cycle pulses on a scored beat
- playing, done  out  1  status levels

Behaviour:
- Reset: state IDLE. All outputs are 0, including the divider, frame and score.
- States: IDLE, FETCH_CURR, FETCH_NEXT, PLAY, DONE.
- Transitions:
  - IDLE/DONE + start → FETCH_CURR. Frame and score are cleared on entry.
  - FETCH_CURR: assert rom_rd for addr 0. The next cycle latches curr lane/hold.
  - FETCH_NEXT: read addr 1 mod SONG_LEN and latch it into next → PLAY. First beat begins with the divider at 0. Start-to-PLAY latency is 4 cycles.
- Divider: counts 0..BEAT_CYCLES-1 only in PLAY with pause low.
  - beat_tick is internal. It fires for 1 cycle at the terminal count.
  - beat = (count < BEAT_CYCLES/2).
- On beat_tick:
  - Scoring:
    - If curr is not a rest, keys==curr_note is a hit: score += POINTS, saturating at SCORE_MAX, and hit pulses.
    - Otherwise miss pulses.
    - Rest beats never score.
  - Hold:
    - If hold_left > 1, decrement it.
    - Otherwise advance: curr <= next, game_frame <= game_frame+1, hold_left <= max(next.hold,1). Then prefetch entry game_frame+2 mod SONG_LEN into next. This takes a 2-cycle ROM access completed long before the next tick.
- End of song: advancing past frame SONG_LEN-1 is governed by TILE_LOOP_EN.
- Pause:
  - Holds every register, including the divider and any in-flight prefetch completion.
  - hit/miss stay 0.
  - start is ignored while paused.
- start during PLAY: ignored.
- Reset mid-operation: immediate return to IDLE. Outputs are cleared asynchronously.
- SONG_LEN==1: next is always entry 0.

Optional Feature:
- Macro TILE_LOOP_EN.
- Defined: after frame SONG_LEN-1, frame wraps to 0 and play continues indefinitely. done never asserts.
- Undefined: the advance out of frame SONG_LEN-1 enters DONE.
  - curr_note, next_note and hold_left clear.
  - beat is low and playing is low.
  - done is high. Score is held until the next start.

Decomposition:
- Package tile_pkg holds:
  - state encoding constants
  - REST-lane encoding rule (index == LANES)
  - the lane-index-to-one-hot conversion function
- One natural sub-module: beat_divider, the parametrised counter producing beat_tick and beat with pause/enable.

Test Plan:
- Bench parameters: LANES=4, SONG_LEN=3, BEAT_CYCLES=4. ROM = {(lane1,hold1),(lane2,hold2),(rest,hold0)}.
- Reset with start held → all outputs 0. Release reset, pulse start → after 4 cycles: playing=1, curr_note=0010, next_note=0100, hold_left=1, frame=0.
- keys=0010 through beat 1 → hit pulse, score=10. Then curr=0100 with hold_left=2. keys=0000 on the next tick → miss, hold_left=1, score stays 10.
- Preload score to saturation by running 999 hits, then one more hit → score stays 9990.
- Without TILE_LOOP_EN: after the rest entry's single beat, done=1, curr_note=0, beat=0. start → frame 0, score 0. With TILE_LOOP_EN: frame 2→0 and curr_note=0010 again.
- pause high for 10 cycles mid-beat → divider, frame, hold_left unchanged and no hit/miss. Resume completes the beat in exactly the remaining cycles.
- Assert reset_n low mid-prefetch → outputs are 0 asynchronously. After release, a start restarts cleanly from frame 0.
